// File: rtl/dmem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wait_ctrl
// Purpose  : Word-organised data memory behind the LSU memory port. Each
//            accepted request sits in a fixed number of wait states, then
//            completes with a one-cycle mem_ready pulse. Reads return the
//            full 32-bit word. Writes are byte-lane masked by mem_be.
//            Sub-word extraction and extension are done by the LSU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   LATENCY     : edges from acceptance edge to the edge where the consumer
//                 samples mem_ready high (>= 1)
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   mem_req    in   1   request valid, held by the requester until mem_ready
//   mem_we     in   1   1 = write, 0 = read
//   mem_be     in   4   byte-enable map, bit n -> bits 8n+7:8n (writes only)
//   mem_addr   in   32  byte address, bits 1:0 ignored
//   mem_wdata  in   32  write data, already lane-replicated
//   mem_rdata  out  32  read word, valid only while mem_ready = 1
//   mem_ready  out  1   one-cycle completion pulse
//   mem_err    out  1   address-range error, high only with mem_ready
// Build option
//   DMEM_RANGE_CHECK_EN : when defined, accesses at mem_addr >= DEPTH_WORDS*4
//                         complete with mem_err = 1, mem_rdata = 0 and no
//                         write. When undefined, mem_err is 0 and high address
//                         bits alias through the truncated word index.
// ============================================================================
module dmem_wait_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_accept;
    logic               w_enter_resp;

    // Request fields captured at acceptance.
    logic               r_we;
    logic [3:0]         r_be;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic               r_oor;

    logic [31:0]        r_rdata;
    logic               r_ready;
    logic               r_err;

    // Storage is deliberately not reset.
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req_oor;
    logic               w_op_we;
    logic [3:0]         w_op_be;
    logic [c_IDX_W-1:0] w_op_idx;
    logic [31:0]        w_op_wdata;
    logic               w_op_oor;
    logic               w_commit_wr;
    logic               w_unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [32:0] c_ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    assign w_req_oor = ({1'b0, mem_addr} >= c_ADDR_LIMIT);
`else
    assign w_req_oor = 1'b0;
`endif

    // Byte-offset bits are never used. The high bits are used only by the
    // range check.
    assign w_unused_addr = ^{mem_addr[31:c_IDX_W+2], mem_addr[1:0]};

    // With LATENCY = 1 the response is entered on the acceptance edge itself,
    // before the request registers hold anything. The operand is therefore
    // taken from the live inputs while in IDLE and from the latched copy after.
    assign w_op_we    = (r_state == c_ST_IDLE) ? mem_we                   : r_we;
    assign w_op_be    = (r_state == c_ST_IDLE) ? mem_be                   : r_be;
    assign w_op_idx   = (r_state == c_ST_IDLE) ? mem_addr[c_IDX_W+1:2]    : r_idx;
    assign w_op_wdata = (r_state == c_ST_IDLE) ? mem_wdata                : r_wdata;
    assign w_op_oor   = (r_state == c_ST_IDLE) ? w_req_oor                : r_oor;

    // Next-state and counter logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (mem_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt  = c_ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            c_ST_WAIT: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt  = c_ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            c_ST_RESP: begin
                // mem_req is not sampled here, so a held request is taken on
                // the following IDLE edge.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State, request capture and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_oor   <= 1'b0;
            r_rdata <= 32'h0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= mem_we;
                r_be    <= mem_be;
                r_idx   <= mem_addr[c_IDX_W+1:2];
                r_wdata <= mem_wdata;
                r_oor   <= w_req_oor;
            end
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp & w_op_oor;
            // Writes leave mem_rdata alone. Out-of-range accesses return zero.
            if (w_enter_resp) begin
                if (w_op_oor) begin
                    r_rdata <= 32'h0;
                end else if (!w_op_we) begin
                    r_rdata <= r_mem[w_op_idx];
                end
            end
        end
    end

    // A write commits only on the edge that enters RESP. Gating with reset
    // keeps a transaction abandoned by reset from landing in the array.
    assign w_commit_wr = reset & w_enter_resp & w_op_we & ~w_op_oor;

    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            for (int n = 0; n < 4; n++) begin
                if (w_op_be[n]) begin
                    r_mem[w_op_idx][8*n +: 8] <= w_op_wdata[8*n +: 8];
                end
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign mem_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wait_ctrl
// Purpose  : Self-checking bench for dmem_wait_ctrl (DEPTH_WORDS=256,
//            LATENCY=2). A vector table drives single accesses. Expected
//            responses are queued at drive time and popped when mem_ready
//            pulses. Hand sequences cover reset idle, back-to-back held
//            requests and reset during a pending write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_wait_ctrl;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    dmem_wait_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (mem_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", {31'd0, mem_ready}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rdata", mem_rdata, e.rd);
                    check("err", {31'd0, mem_err}, {31'd0, e.err});
                end
            end else begin
                check("err_outside_resp", {31'd0, mem_err}, 32'd0);
            end
        end
    end

    task automatic drive_idle();
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
    endtask

    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err);
        int   cyc;
        exp_t e;
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_be    = be;
        mem_addr  = addr;
        mem_wdata = wdata;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb_q.push_back(e);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_ready && cyc < 20);
        drive_idle();
        check("latency", 32'(cyc), 32'(LAT));
    endtask

    initial begin
        int t1;
        int t2;
        int pulses;
        exp_t e;

        drive_idle();
        reset = 1'b0;

        // Reset held with no request: outputs stay at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {31'd0, mem_ready}, 32'd0);
            check("rst_rdata", mem_rdata, 32'd0);
            check("rst_err", {31'd0, mem_err}, 32'd0);
        end
        reset = 1'b1;

        //             we    be     addr        wdata         exp_rd        err
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 4'h4, 32'h0000_0012, 32'h5555_5555, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDE55_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'hDE55_BEEF, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_0013, 32'h0000_0000, 32'hDE55_BEEF, 1'b0};
        vecs[8]  = '{1'b1, 4'hF, 32'h0000_03FC, 32'hA5A5_A5A5, 32'hDE55_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 4'h9, 32'h0000_03FC, 32'h1122_3344, 32'hDE55_BEEF, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_03FC, 32'h0000_0000, 32'h11A5_A544, 1'b0};
`ifdef DMEM_RANGE_CHECK_EN
        vecs[11] = '{1'b1, 4'hF, 32'h0000_0400, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
`else
        vecs[11] = '{1'b1, 4'hF, 32'h0000_0400, 32'hAAAA_AAAA, 32'h11A5_A544, 1'b0};
        vecs[12] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'hAAAA_AAAA, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0400, 32'h0000_0000, 32'hAAAA_AAAA, 1'b0};
`endif
        vecs[14] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};

        for (int v = 0; v < 15; v++) begin
            access(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp_rd, vecs[v].exp_err);
        end

        // Back-to-back reads with mem_req held high. The address changes
        // during WAIT, so the second access must pick up the new address.
        @(negedge clk);
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0010;
        e.rd = 32'hDE55_BEEF; e.err = 1'b0; sb_q.push_back(e);
        e.rd = 32'h11A5_A544; e.err = 1'b0; sb_q.push_back(e);
        t1 = -1;
        t2 = -1;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) mem_addr = 32'h0000_03FC;
            if (mem_ready) begin
                pulses++;
                if (t1 < 0) begin
                    t1 = i;
                end else if (t2 < 0) begin
                    t2 = i;
                    drive_idle();
                end
            end
        end
        drive_idle();
        check("b2b_first_latency", 32'(t1), 32'(LAT));
        check("b2b_spacing", 32'(t2 - t1), 32'(LAT + 1));
        check("b2b_pulses", 32'(pulses), 32'd2);

        // Reset during WAIT drops the pending write and suppresses ready.
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be    = 4'hF;
        mem_addr  = 32'h0000_0020;
        mem_wdata = 32'h1234_5678;
        @(negedge clk);
        drive_idle();
        #2 reset = 1'b0;
        @(negedge clk);
        check("midrst_rdata", mem_rdata, 32'd0);
        check("midrst_ready", {31'd0, mem_ready}, 32'd0);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("midrst_no_ready", 32'(pulses), 32'd0);
        access(1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
